// File: rtl/point_placer_ctrl_pkg.sv
// Shared snake-game types used by the point placer.
//   tile_t        : contents of one map tile
//   game_mode     : MENU / GAME
//   point_state_e : point placer FSM states (scan states exist only when
//                   POINT_SCAN_FALLBACK_EN is defined)
//   MAP_WIDTH/MAP_HEIGHT : default map size
//   lfsr5_next    : 5-bit LFSR step shared by every LFSR user
package point_placer_ctrl_pkg;

    localparam int MAP_WIDTH  = 32;
    localparam int MAP_HEIGHT = 24;

    typedef enum logic [2:0] {
        EMPTY  = 3'd0,
        SNAKE1 = 3'd1,
        SNAKE2 = 3'd2,
        WALL   = 3'd3,
        POINT  = 3'd4
    } tile_t;

    typedef enum logic {
        MENU = 1'b0,
        GAME = 1'b1
    } game_mode;

    typedef enum logic [2:0] {
        IDLE       = 3'd0,
        ISSUE      = 3'd1,
        EVAL       = 3'd2,
`ifdef POINT_SCAN_FALLBACK_EN
        COMMIT     = 3'd3,
        SCAN_ISSUE = 3'd4,
        SCAN_EVAL  = 3'd5
`else
        COMMIT     = 3'd3
`endif
    } point_state_e;

    // Feedback taps s[4] into bit 0 and bit 1; a non-zero state never maps to 0.
    function automatic logic [4:0] lfsr5_next(input logic [4:0] s);
        return {s[3], s[2], s[1], s[0] ^ s[4], s[4]};
    endfunction

endpackage

// File: rtl/point_lfsr.sv
// 5-bit LFSR for point coordinate candidates.
//   clk_i/rst_i : clock, synchronous active-high reset (state -> 5'd1)
//   load_i      : load seed_i (a zero seed is replaced by 1)
//   step_i      : advance one step
//   nxt_o       : value the LFSR takes on the next step
module point_lfsr
    import point_placer_ctrl_pkg::*;
(
    input  logic       clk_i,
    input  logic       rst_i,
    input  logic       load_i,
    input  logic       step_i,
    input  logic [4:0] seed_i,
    output logic [4:0] nxt_o
);
    logic [4:0] s_q;

    assign nxt_o = lfsr5_next(s_q);

    always_ff @(posedge clk_i) begin
        if (rst_i)       s_q <= 5'd1;
        else if (load_i) s_q <= (seed_i == 5'd0) ? 5'd1 : seed_i;
        else if (step_i) s_q <= nxt_o;
    end
endmodule

// File: rtl/point_placer_ctrl.sv
// Food point placement controller.
// Draws random interior coordinates, probes the tile through a read port and
// commits the first EMPTY one. With POINT_SCAN_FALLBACK_EN defined, after
// MAX_TRIES failed random probes it raster-scans the interior and raises
// map_full when no EMPTY tile exists; otherwise map_full is tied low.
// Ports:
//   clk_75, rst                : clock, synchronous active-high reset
//   mode                       : MENU / GAME
//   seed_x_in, seed_y_in       : LFSR seeds, loaded on MENU->GAME
//   eat1, eat2                 : snake ate the point (single-cycle pulses)
//   rd_x, rd_y / rd_tile       : tile read address (registered) / tile data
//   point_x, point_y           : committed coordinates
//   point_valid, busy          : point on map / placement in progress
//   place_done, map_full       : commit pulse / no EMPTY tile found
module point_placer_ctrl #(
    parameter int MAP_WIDTH  = point_placer_ctrl_pkg::MAP_WIDTH,
    parameter int MAP_HEIGHT = point_placer_ctrl_pkg::MAP_HEIGHT,
    parameter int MAX_TRIES  = 8
) (
    input  logic                           clk_75,
    input  logic                           rst,
    input  point_placer_ctrl_pkg::game_mode mode,
    input  logic [4:0]                     seed_x_in,
    input  logic [4:0]                     seed_y_in,
    input  logic                           eat1,
    input  logic                           eat2,
    output logic [4:0]                     rd_x,
    output logic [4:0]                     rd_y,
    input  point_placer_ctrl_pkg::tile_t    rd_tile,
    output logic [4:0]                     point_x,
    output logic [4:0]                     point_y,
    output logic                           point_valid,
    output logic                           busy,
    output logic                           place_done,
    output logic                           map_full
);
    import point_placer_ctrl_pkg::*;

    localparam logic [4:0] X_SPAN = 5'(MAP_WIDTH - 2);
    localparam logic [4:0] Y_SPAN = 5'(MAP_HEIGHT - 2);
    localparam int         TW     = (MAX_TRIES > 1) ? $clog2(MAX_TRIES) : 1;

    point_state_e state_q, state_d;
    game_mode     mode_q;
    logic [4:0]   rd_x_q, rd_x_d, rd_y_q, rd_y_d;
    logic [4:0]   pt_x_q, pt_x_d, pt_y_q, pt_y_d;
    logic         pv_q, pv_d, done_q, done_d;
    logic [TW-1:0] tries_q, tries_d;
    logic         lfsr_step;
    logic [4:0]   x_nxt, y_nxt;
`ifdef POINT_SCAN_FALLBACK_EN
    logic [4:0]   scan_x_q, scan_x_d, scan_y_q, scan_y_d;
    logic         full_q, full_d;
`endif

    wire game_start = (mode == GAME) && (mode_q == MENU);

    point_lfsr u_lfsr_x (
        .clk_i(clk_75), .rst_i(rst), .load_i(game_start),
        .step_i(lfsr_step), .seed_i(seed_x_in), .nxt_o(x_nxt)
    );
    point_lfsr u_lfsr_y (
        .clk_i(clk_75), .rst_i(rst), .load_i(game_start),
        .step_i(lfsr_step), .seed_i(seed_y_in), .nxt_o(y_nxt)
    );

    always_comb begin
        state_d   = state_q;
        rd_x_d    = rd_x_q;
        rd_y_d    = rd_y_q;
        pt_x_d    = pt_x_q;
        pt_y_d    = pt_y_q;
        pv_d      = pv_q;
        done_d    = 1'b0;
        tries_d   = tries_q;
        lfsr_step = 1'b0;
`ifdef POINT_SCAN_FALLBACK_EN
        scan_x_d  = scan_x_q;
        scan_y_d  = scan_y_q;
        full_d    = full_q;
`endif
        if (mode != GAME) begin
            // Leaving the game abandons any placement; LFSRs keep their state.
            state_d = IDLE;
            pv_d    = 1'b0;
            tries_d = '0;
`ifdef POINT_SCAN_FALLBACK_EN
            full_d  = 1'b0;
`endif
        end else begin
            case (state_q)
                IDLE: begin
                    if (game_start) begin
                        state_d = ISSUE;
                    end else if ((eat1 | eat2) && pv_q) begin
                        pv_d    = 1'b0;
                        state_d = ISSUE;
                    end
                end
                ISSUE: begin
                    lfsr_step = 1'b1;
                    rd_x_d    = (x_nxt % X_SPAN) + 5'd1;
                    rd_y_d    = (y_nxt % Y_SPAN) + 5'd1;
                    state_d   = EVAL;
                end
                EVAL: begin
                    if (rd_tile == EMPTY) begin
                        state_d = COMMIT;
`ifdef POINT_SCAN_FALLBACK_EN
                    end else if (tries_q == TW'(MAX_TRIES - 1)) begin
                        tries_d  = '0;
                        scan_x_d = 5'd1;
                        scan_y_d = 5'd1;
                        state_d  = SCAN_ISSUE;
`endif
                    end else begin
                        tries_d = tries_q + TW'(1);
                        state_d = ISSUE;
                    end
                end
                COMMIT: begin
                    pt_x_d  = rd_x_q;
                    pt_y_d  = rd_y_q;
                    pv_d    = 1'b1;
                    done_d  = 1'b1;
                    tries_d = '0;
`ifdef POINT_SCAN_FALLBACK_EN
                    full_d  = 1'b0;
`endif
                    state_d = IDLE;
                end
`ifdef POINT_SCAN_FALLBACK_EN
                SCAN_ISSUE: begin
                    rd_x_d  = scan_x_q;
                    rd_y_d  = scan_y_q;
                    state_d = SCAN_EVAL;
                end
                SCAN_EVAL: begin
                    if (rd_tile == EMPTY) begin
                        state_d = COMMIT;
                    end else if (scan_x_q == X_SPAN && scan_y_q == Y_SPAN) begin
                        full_d  = 1'b1;
                        pv_d    = 1'b0;
                        state_d = IDLE;
                    end else begin
                        // x is the inner loop of the raster
                        if (scan_x_q == X_SPAN) begin
                            scan_x_d = 5'd1;
                            scan_y_d = scan_y_q + 5'd1;
                        end else begin
                            scan_x_d = scan_x_q + 5'd1;
                        end
                        state_d = SCAN_ISSUE;
                    end
                end
`endif
                default: state_d = IDLE;
            endcase
        end
    end

    always_ff @(posedge clk_75) begin
        if (rst) begin
            state_q  <= IDLE;
            mode_q   <= MENU;
            rd_x_q   <= 5'd0;
            rd_y_q   <= 5'd0;
            pt_x_q   <= 5'd0;
            pt_y_q   <= 5'd0;
            pv_q     <= 1'b0;
            done_q   <= 1'b0;
            tries_q  <= '0;
`ifdef POINT_SCAN_FALLBACK_EN
            scan_x_q <= 5'd1;
            scan_y_q <= 5'd1;
            full_q   <= 1'b0;
`endif
        end else begin
            state_q  <= state_d;
            mode_q   <= mode;
            rd_x_q   <= rd_x_d;
            rd_y_q   <= rd_y_d;
            pt_x_q   <= pt_x_d;
            pt_y_q   <= pt_y_d;
            pv_q     <= pv_d;
            done_q   <= done_d;
            tries_q  <= tries_d;
`ifdef POINT_SCAN_FALLBACK_EN
            scan_x_q <= scan_x_d;
            scan_y_q <= scan_y_d;
            full_q   <= full_d;
`endif
        end
    end

    assign rd_x        = rd_x_q;
    assign rd_y        = rd_y_q;
    assign point_x     = pt_x_q;
    assign point_y     = pt_y_q;
    assign point_valid = pv_q;
    assign place_done  = done_q;
    assign busy        = (state_q != IDLE);
`ifdef POINT_SCAN_FALLBACK_EN
    assign map_full    = full_q;
`else
    assign map_full    = 1'b0;
`endif
endmodule

// File: tb/tb_point_placer_ctrl.sv
module tb_point_placer_ctrl;
    import point_placer_ctrl_pkg::*;

    localparam int W = 32;
    localparam int H = 24;
    localparam int MAX_TRIES = 8;
`ifdef POINT_SCAN_FALLBACK_EN
    localparam int PROBE_LIMIT = MAX_TRIES;
`else
    localparam int PROBE_LIMIT = 64;
`endif

    logic       clk_75 = 1'b0;
    logic       rst = 1'b1;
    game_mode   mode = MENU;
    logic [4:0] seed_x_in = 5'd0, seed_y_in = 5'd0;
    logic       eat1 = 1'b0, eat2 = 1'b0;
    logic [4:0] rd_x, rd_y, point_x, point_y;
    tile_t      rd_tile;
    logic       point_valid, busy, place_done, map_full;

    tile_t      map [0:31][0:31];
    logic [4:0] mx, my;           // reference LFSR values
    int         n_pass = 0, n_fail = 0, n_total = 0;

    always #5 clk_75 = ~clk_75;

    // Read port: data for the address registered at the previous edge.
    assign rd_tile = map[rd_x][rd_y];

    point_placer_ctrl dut (
        .clk_75(clk_75), .rst(rst), .mode(mode),
        .seed_x_in(seed_x_in), .seed_y_in(seed_y_in),
        .eat1(eat1), .eat2(eat2),
        .rd_x(rd_x), .rd_y(rd_y), .rd_tile(rd_tile),
        .point_x(point_x), .point_y(point_y),
        .point_valid(point_valid), .busy(busy),
        .place_done(place_done), .map_full(map_full)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_total++;
        assert (obs === exp) n_pass++;
        else begin
            n_fail++;
            $error("FAIL %s: got %0d want %0d", tag, obs, exp);
        end
    endtask

    // Reference LFSR: shift left, fold the top bit back in with mask 5'b00011.
    function automatic logic [4:0] m_next(input logic [4:0] s);
        return 5'(((s * 2) % 32) ^ ((s >= 16) ? 3 : 0));
    endfunction
    function automatic logic [4:0] m_seed(input logic [4:0] s);
        return (s == 0) ? 5'd1 : s;
    endfunction
    function automatic logic [4:0] cand_x(input logic [4:0] s);
        return 5'((s % (W - 2)) + 1);
    endfunction
    function automatic logic [4:0] cand_y(input logic [4:0] s);
        return 5'((s % (H - 2)) + 1);
    endfunction

    task automatic step();
        @(posedge clk_75);
        #1;
    endtask

    task automatic peek(input int k, output logic [4:0] x, output logic [4:0] y);
        logic [4:0] sx, sy;
        sx = mx; sy = my;
        for (int i = 0; i <= k; i++) begin
            sx = m_next(sx); sy = m_next(sy);
        end
        x = cand_x(sx); y = cand_y(sy);
    endtask

    task automatic fill_map(input int density, input tile_t t);
        for (int x = 0; x < 32; x++)
            for (int y = 0; y < 32; y++)
                if (density >= 100) map[x][y] = t;
                else map[x][y] = (int'($urandom_range(99)) < density) ? tile_t'($urandom_range(4, 1)) : EMPTY;
    endtask

    task automatic chk_reset(input string t);
        chk({t, ".point_x"}, 32'(point_x), 0);
        chk({t, ".point_y"}, 32'(point_y), 0);
        chk({t, ".rd_x"}, 32'(rd_x), 0);
        chk({t, ".rd_y"}, 32'(rd_y), 0);
        chk({t, ".point_valid"}, 32'(point_valid), 0);
        chk({t, ".busy"}, 32'(busy), 0);
        chk({t, ".place_done"}, 32'(place_done), 0);
        chk({t, ".map_full"}, 32'(map_full), 0);
    endtask

    task automatic start_game(input logic [4:0] sx, input logic [4:0] sy);
        seed_x_in = sx; seed_y_in = sy; mode = GAME;
        mx = m_seed(sx); my = m_seed(sy);
    endtask

    // Trigger applied in the current cycle; predicts the outcome from the
    // bench map and the reference LFSR, then follows the DUT until idle.
    task automatic expect_place(input string tag, input int poke);
        logic [4:0] sx, sy, cx, cy, fx, fy;
        int fails, cyc, lat, pulses;
        bit found, pv_early;
        sx = mx; sy = my; fails = 0; found = 0;
        cx = 0; cy = 0; fx = 0; fy = 0;
        for (int k = 0; k < PROBE_LIMIT && !found; k++) begin
            sx = m_next(sx); sy = m_next(sy);
            cx = cand_x(sx); cy = cand_y(sy);
            if (k == 0) begin fx = cx; fy = cy; end
            if (map[cx][cy] == EMPTY) found = 1;
            else fails++;
        end
`ifdef POINT_SCAN_FALLBACK_EN
        for (int y = 1; y <= H - 2 && !found; y++)
            for (int x = 1; x <= W - 2 && !found; x++) begin
                cx = 5'(x); cy = 5'(y);
                if (map[x][y] == EMPTY) found = 1;
                else fails++;
            end
`endif
        mx = sx; my = sy;
        lat = found ? 4 + 2 * fails : 2 * fails + 1;

        cyc = 0; pv_early = 0;
        do begin
            step();
            cyc++;
            eat1 = (cyc == poke); eat2 = 1'b0;
            if (cyc == 2) begin
                chk({tag, ".rd_x"}, 32'(rd_x), 32'(fx));
                chk({tag, ".rd_y"}, 32'(rd_y), 32'(fy));
            end
            if (busy && point_valid) pv_early = 1;
        end while (busy && cyc < 3000);

        chk({tag, ".latency"}, cyc, lat);
        chk({tag, ".pv_low"}, 32'(pv_early), 0);
        chk({tag, ".place_done"}, 32'(place_done), 32'(found));
        chk({tag, ".point_valid"}, 32'(point_valid), 32'(found));
        chk({tag, ".map_full"}, 32'(map_full), 32'(!found));
        if (found) begin
            chk({tag, ".point_x"}, 32'(point_x), 32'(cx));
            chk({tag, ".point_y"}, 32'(point_y), 32'(cy));
        end
        pulses = 0;
        for (int i = 0; i < 3; i++) begin
            step();
            pulses += int'(place_done) + int'(busy);
        end
        chk({tag, ".quiet"}, pulses, 0);
    endtask

    initial begin
        logic [4:0] cx, cy;
        int k, e;

        fill_map(100, EMPTY);
        rst = 1'b1; mode = MENU;
        repeat (3) step();
        chk_reset("rst");
        rst = 1'b0;
        step();
        chk_reset("rst_rel");

        // Game start, empty map: first candidate commits 4 cycles later.
        start_game(5'd5, 5'd7);
        expect_place("start", 0);

        // Both snakes eat at once: exactly one placement.
        eat1 = 1'b1; eat2 = 1'b1;
        expect_place("dual_eat", 0);

        // First three candidates blocked by snake 1; an extra eat while busy.
        fill_map(100, EMPTY);
        for (int i = 0; i < 3; i++) begin
            peek(i, cx, cy);
            map[cx][cy] = SNAKE1;
        end
        eat1 = 1'b1;
        expect_place("retry3", 2);

        // Random obstacle maps, with a guaranteed EMPTY candidate early.
        for (int r = 0; r < 6; r++) begin
            fill_map(60, EMPTY);
            k = $urandom_range(5);
            peek(k, cx, cy);
            map[cx][cy] = EMPTY;
            e = $urandom_range(3, 1);
            eat1 = e[0]; eat2 = e[1];
            expect_place("rand_eat", $urandom_range(3, 1));
        end

        // Leaving the game during ISSUE; later eat is ignored.
        eat1 = 1'b1;
        step();
        eat1 = 1'b0;
        chk("ml.busy_issue", 32'(busy), 1);
        mode = MENU;
        step();
        chk("ml.busy", 32'(busy), 0);
        chk("ml.point_valid", 32'(point_valid), 0);
        eat1 = 1'b1;
        step();
        eat1 = 1'b0;
        step();
        chk("ml.eat_ignored", 32'(busy), 0);
        chk("ml.pv_still_low", 32'(point_valid), 0);

        // Reset while the FSM sits in EVAL.
        fill_map(100, EMPTY);
        start_game(5'd9, 5'd20);
        peek(0, cx, cy);
        step();
        step();
        chk("re.rd_x", 32'(rd_x), 32'(cx));
        chk("re.busy", 32'(busy), 1);
        rst = 1'b1;
        step();
        chk_reset("rst_eval");
        mode = MENU;
        rst = 1'b0;
        step();
        mx = 5'd1; my = 5'd1;

        // Zero seeds fall back to 1.
        fill_map(50, EMPTY);
        start_game(5'd0, 5'd0);
        k = $urandom_range(4);
        peek(k, cx, cy);
        map[cx][cy] = EMPTY;
        expect_place("zero_seed", 0);

`ifdef POINT_SCAN_FALLBACK_EN
        // Only (4,1) is free: random probes almost surely miss, scan finds it.
        fill_map(100, SNAKE2);
        map[4][1] = EMPTY;
        eat1 = 1'b1;
        expect_place("scan41", 0);

        // Nothing free: scan runs to the end and flags map_full.
        map[4][1] = WALL;
        eat2 = 1'b1;
        expect_place("full", 0);
`endif

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end
endmodule

// File: doc/point_placer_ctrl.md
# point_placer_ctrl

Controller that decides where the next food POINT goes on the game map and sequences its placement. It sits between the snake movement/collision logic and the map-update stage, which writes POINT into the tile array at the committed coordinates. On game start or on a snake eating the current point, it draws candidate coordinates from a 5-bit LFSR pair. It probes each candidate tile through a read port and commits only a tile that is EMPTY.

## Interface
Parameters:
- MAP_WIDTH, 32, map columns; legal point x range is 1..MAP_WIDTH-2.
- MAP_HEIGHT, 24, map rows; legal point y range is 1..MAP_HEIGHT-2.
- MAX_TRIES, 8, random probes allowed before fallback; only used with the scan feature.

Ports:
- clk_75 — in, 1: single clock.
- rst — in, 1: reset, synchronous, active-high.
- mode — in, game_mode: MENU or GAME.
- seed_x_in, seed_y_in — in, 5 each: LFSR seeds, sampled on entry to GAME.
- eat1, eat2 — in, 1 each: single-cycle pulse when snake 1 or snake 2 head lands on the point.
- rd_x, rd_y — out, 5 each: tile read address, registered.
- rd_tile — in, tile_t: tile at the rd_x/rd_y presented in the previous cycle.
- point_x, point_y — out, 5 each: committed point coordinates.
- point_valid — out, 1: committed point exists on the map.
- busy — out, 1: placement in progress.
- place_done — out, 1: one-cycle pulse on commit.
- map_full — out, 1: no EMPTY interior tile was found.

## Operation
- Reset values: state IDLE, point_x=0, point_y=0, rd_x=0, rd_y=0, point_valid=0, busy=0, place_done=0, map_full=0, LFSR pair = 5'd1/5'd1.
- States are IDLE, ISSUE, EVAL, COMMIT, plus SCAN_ISSUE and SCAN_EVAL when POINT_SCAN_FALLBACK_EN is defined.
- Start of a game: a MENU→GAME transition (previous-cycle mode register) loads LFSR x/y from seed_x_in/seed_y_in, substituting 1 for a 0 seed. The FSM then goes to ISSUE.
- Eating: eat1|eat2 while point_valid=1 and state IDLE clears point_valid and goes to ISSUE.
  - Simultaneous eat1 and eat2 trigger one placement.
  - Eat pulses while point_valid=0 or busy=1 are ignored.
- ISSUE: step both LFSRs with next = {s[3],s[2],s[1],s[0]^s[4],s[4]}. Drive rd_x = next_x%(MAP_WIDTH-2)+1 and rd_y = next_y%(MAP_HEIGHT-2)+1, then go to EVAL.
- EVAL:
  - rd_tile==EMPTY goes to COMMIT.
  - Otherwise, increment the try counter and return to ISSUE.
- COMMIT: point_x/point_y ← rd_x/rd_y, point_valid=1, place_done=1 for one cycle, try counter cleared, map_full=0, then IDLE.
- busy=1 in every state except IDLE.
- mode≠GAME in any state forces IDLE, point_valid=0 and map_full=0 on the next edge. The LFSRs hold their value.
- Width rules: modulo and +1 are computed in 5 bits. Results never exceed 30 (x) or 22 (y) with default parameters.

## Timing
- Eat pulse at cycle N puts the FSM in ISSUE at N+1 and EVAL at N+2 (rd_x/rd_y valid). rd_tile is sampled at N+2 and the FSM is in COMMIT at N+3.
- point_x, point_y, point_valid and place_done are visible at N+4.
- Each failed probe adds 2 cycles.
- rd_tile latency is exactly one cycle after rd_x/rd_y. No other handshake exists.
- rst mid-placement returns every output to its reset value on the same edge.

## Configuration
- POINT_SCAN_FALLBACK_EN defined:
  - After MAX_TRIES consecutive non-EMPTY probes, the FSM enters SCAN_ISSUE. It raster-scans from (1,1), x inner loop, up to (MAP_WIDTH-2, MAP_HEIGHT-2), with 2 cycles per tile.
  - The first EMPTY tile goes to COMMIT.
  - If scan end is reached with no EMPTY tile: map_full=1, point_valid=0, back to IDLE.
- Not defined: no scan states. Random probing repeats until an EMPTY tile is found, and map_full is tied 0.

## Structure
- Shared snake package holds tile_t, game_mode, MAP_WIDTH/MAP_HEIGHT constants, and the new point_state_e enum.
- One sub-module, point_lfsr: 5-bit LFSR with load, step enable and zero-seed substitution. It is instantiated twice, for x and y.

## Test plan
- Reset, then mode MENU→GAME with seeds 5/7 → first probe at rd_x=(lfsr(5)%30)+1, rd_y=(lfsr(7)%22)+1. With rd_tile=EMPTY, point_valid=1 and place_done pulse 4 cycles after the transition.
- Point valid, eat1 and eat2 pulse in the same cycle → exactly one place_done. point_valid low for ≥3 cycles, then high at new coordinates.
- rd_tile=SNAKE1 for 3 probes then EMPTY → commit at the 4th candidate, place_done 10 cycles after the eat.
- With POINT_SCAN_FALLBACK_EN, only tile (4,1) EMPTY → after 8 failures, scan commits (4,1). With every tile non-EMPTY → map_full=1, point_valid=0.
- rst asserted during EVAL → next cycle all outputs at reset values, state IDLE.
- mode→MENU during ISSUE → busy=0 and point_valid=0 next cycle. A later eat pulse is ignored.
